// File: rtl/bsalu_pkg.sv
// Shared encodings for the bit-serial ALU sequencer: opcodes, FSM states and per-op initial carry.
package bsalu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Indexed by opcode: SUB starts with carry 1 (A + ~B + 1), all others with 0.
  localparam logic [3:0] INIT_CARRY = 4'b0010;

  function automatic logic init_carry(input logic [1:0] op);
    return INIT_CARRY[op];
  endfunction

endpackage

// File: rtl/bsalu_shreg.sv
// WIDTH-bit register: parallel load, or shift right with a new bit entering at the MSB.
// Load wins over shift; bit 0 is exposed separately for the serial consumer.
module bsalu_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_dat,
  input  logic             shift_en,
  input  logic             shift_in,
  output logic [WIDTH-1:0] q,
  output logic             bit0
);

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load_en) begin
      q_d = load_dat;
    end else if (shift_en) begin
      q_d = {shift_in, q_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q    = q_q;
  assign bit0 = q_q[0];

endmodule

// File: rtl/bit_serial_alu_ctrl.sv
// Sequences an external 1-bit ALU slice over WIDTH bits, LSB first; Done pulses WIDTH+1 cycles after Start.
// Start is only honoured in IDLE (no queueing); optional Overflow output under BSALU_OVERFLOW_EN.
module bit_serial_alu_ctrl
  import bsalu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             ResetN,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
  output logic             SliceA,
  output logic             SliceB,
  output logic             SliceCin,
  output logic             SliceS1,
  output logic             SliceS2,
  input  logic             SliceCarrySum,
  input  logic             SliceBorrow,
  input  logic             SliceResAlu
`ifdef BSALU_OVERFLOW_EN
  ,
  output logic             Overflow
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic             carry_out_q, carry_out_d;
  logic             ovf_q, ovf_d;

  logic             load_en, shift_en;
  logic             arith, new_carry;
  logic             a_bit0, b_bit0;
  logic [WIDTH-1:0] a_word_unused, b_word_unused;
  logic             res_bit0_unused;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;
    ovf_d       = ovf_q;
    load_en     = 1'b0;
    shift_en    = 1'b0;
    Busy        = 1'b0;
    Done        = 1'b0;
    SliceA      = 1'b0;
    SliceB      = 1'b0;
    SliceCin    = 1'b0;
    SliceS1     = 1'b0;
    SliceS2     = 1'b0;
    arith       = (op_q == OP_ADD) || (op_q == OP_SUB);
    new_carry   = 1'b0;
    if (op_q == OP_ADD)      new_carry = SliceCarrySum;
    else if (op_q == OP_SUB) new_carry = SliceBorrow;

    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = SHIFT;
          op_d    = Op;
          cnt_d   = '0;
          carry_d = init_carry(Op);
          load_en = 1'b1;
        end
      end
      SHIFT: begin
        Busy               = 1'b1;
        SliceA             = a_bit0;
        SliceB             = b_bit0;
        SliceCin           = arith & carry_q;
        {SliceS2, SliceS1} = op_q;
        shift_en           = 1'b1;
        carry_d            = new_carry;
        cnt_d              = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // Last bit: the incoming carry is the MSB carry-in, new_carry its carry-out.
          state_d     = DONE;
          cnt_d       = '0;
          carry_out_d = new_carry;
          ovf_d       = arith & (carry_q ^ new_carry);
        end
      end
      DONE: begin
        Done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= OP_ADD;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
      ovf_q       <= ovf_d;
    end
  end

  bsalu_shreg #(.WIDTH(WIDTH)) u_a_reg (
    .clk(CLK), .rst_n(ResetN), .load_en(load_en), .load_dat(OpA),
    .shift_en(shift_en), .shift_in(1'b0), .q(a_word_unused), .bit0(a_bit0)
  );

  bsalu_shreg #(.WIDTH(WIDTH)) u_b_reg (
    .clk(CLK), .rst_n(ResetN), .load_en(load_en), .load_dat(OpB),
    .shift_en(shift_en), .shift_in(1'b0), .q(b_word_unused), .bit0(b_bit0)
  );

  bsalu_shreg #(.WIDTH(WIDTH)) u_res_reg (
    .clk(CLK), .rst_n(ResetN), .load_en(1'b0), .load_dat('0),
    .shift_en(shift_en), .shift_in(SliceResAlu), .q(Result), .bit0(res_bit0_unused)
  );

  assign CarryOut = carry_out_q;
`ifdef BSALU_OVERFLOW_EN
  assign Overflow = ovf_q;
`endif

endmodule
